// File: rtl/coin_disp_fmt_if.sv
// Load/done handshake and display result bundle between the coin datapath and the
// money-to-display formatter.
interface coin_disp_fmt_if #(
  parameter int unsigned VAL_W      = 8,
  parameter int unsigned INT_DIGITS = 2
);
  logic                    load;
  logic [VAL_W-1:0]        value;
  logic                    busy;
  logic                    done;
  logic [4*INT_DIGITS-1:0] int_bcd;
  logic [3:0]              frac_bcd;
  logic                    dp;
  logic [INT_DIGITS-1:0]   blank;
  logic                    ovf;

  modport master (
    output load, value,
    input  busy, done, int_bcd, frac_bcd, dp, blank, ovf
  );

  modport slave (
    input  load, value,
    output busy, done, int_bcd, frac_bcd, dp, blank, ovf
  );
endinterface

// File: rtl/coin_disp_fmt.sv
// Coin total to BCD display formatter: serial double-dabble conversion, one bit per clock,
// with half-unit tenths digit, leading-zero blanking and saturation on overflow.
module coin_disp_fmt #(
  parameter int unsigned VAL_W      = 8,
  parameter int unsigned INT_DIGITS = 2,
  parameter int unsigned HALF_UNIT  = 1,
  parameter int unsigned BLANK_LZ   = 1
) (
  input logic             clk,
  input logic             rst,
  coin_disp_fmt_if.slave  disp
);

  localparam int unsigned IW = VAL_W - HALF_UNIT;

  function automatic int unsigned dec_digits(int unsigned w);
    longint unsigned v;
    int unsigned     n;
    v = (64'd1 << w) - 64'd1;
    n = 1;
    for (int k = 0; k < 20; k++) begin
      if (v >= 64'd10) begin
        v = v / 64'd10;
        n++;
      end
    end
    return n;
  endfunction

  function automatic longint unsigned pow10(int unsigned n);
    longint unsigned p;
    p = 64'd1;
    for (int unsigned k = 0; k < n; k++) p = p * 64'd10;
    return p;
  endfunction

  // Guard nibbles let the accumulator hold any IW-bit value before saturation is applied.
  localparam int unsigned NumDig = dec_digits(IW);
  localparam int unsigned AccD   = (NumDig > INT_DIGITS) ? NumDig : INT_DIGITS;
  localparam int unsigned AccW   = 4 * AccD;
  localparam int unsigned CntW   = $clog2(IW + 1);
  localparam longint unsigned MaxInt = pow10(INT_DIGITS) - 64'd1;
  localparam logic [INT_DIGITS-1:0] RstBlank =
      (BLANK_LZ != 0) ? ~INT_DIGITS'(1) : '0;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StShift  = 2'd1;
  localparam logic [1:0] StFinish = 2'd2;

  logic [1:0]              state_q, state_d;
  logic [IW-1:0]           sh_q, sh_d;
  logic [AccW-1:0]         acc_q, acc_d, adj;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    half_q, half_d;
  logic                    ovf_cap_q, ovf_cap_d;
  logic [4*INT_DIGITS-1:0] int_q, int_d, fin_int;
  logic [3:0]              frac_q, frac_d;
  logic [INT_DIGITS-1:0]   blank_q, blank_d, fin_blank;
  logic                    ovf_q, ovf_d;
  logic                    done_q, done_d;
  logic [IW-1:0]           i_cap;
  logic                    h_cap, fin_half, seen_nz;

  assign i_cap = IW'(disp.value >> HALF_UNIT);
  assign h_cap = (HALF_UNIT != 0) && disp.value[0];

  always_comb begin
    adj = acc_q;
    for (int d = 0; d < int'(AccD); d++) begin
      if (acc_q[4*d+:4] >= 4'd5) adj[4*d+:4] = acc_q[4*d+:4] + 4'd3;
    end
  end

  // Final result: saturate on overflow, then blank zeros above the highest nonzero digit.
  always_comb begin
    fin_int   = ovf_cap_q ? {INT_DIGITS{4'h9}} : acc_q[4*INT_DIGITS-1:0];
    fin_half  = ovf_cap_q ? (HALF_UNIT != 0) : half_q;
    fin_blank = '0;
    seen_nz   = 1'b0;
    for (int i = int'(INT_DIGITS) - 1; i >= 0; i--) begin
      seen_nz      = seen_nz | (fin_int[4*i+:4] != 4'd0);
      fin_blank[i] = (BLANK_LZ != 0) && (i != 0) && !seen_nz;
    end
  end

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    half_d    = half_q;
    ovf_cap_d = ovf_cap_q;
    int_d     = int_q;
    frac_d    = frac_q;
    blank_d   = blank_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (disp.load) begin
          sh_d      = i_cap;
          half_d    = h_cap;
          acc_d     = '0;
          cnt_d     = '0;
          ovf_cap_d = 64'(i_cap) > MaxInt;
          state_d   = StShift;
        end
      end
      StShift: begin
        acc_d = AccW'({adj, sh_q[IW-1]});
        sh_d  = sh_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(IW - 1)) state_d = StFinish;
      end
      StFinish: begin
        int_d   = fin_int;
        frac_d  = fin_half ? 4'd5 : 4'd0;
        ovf_d   = ovf_cap_q;
        blank_d = fin_blank;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      sh_q      <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      half_q    <= 1'b0;
      ovf_cap_q <= 1'b0;
      int_q     <= '0;
      frac_q    <= '0;
      blank_q   <= RstBlank;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      half_q    <= half_d;
      ovf_cap_q <= ovf_cap_d;
      int_q     <= int_d;
      frac_q    <= frac_d;
      blank_q   <= blank_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  assign disp.busy     = (state_q != StIdle);
  assign disp.done     = done_q;
  assign disp.int_bcd  = int_q;
  assign disp.frac_bcd = frac_q;
  assign disp.dp       = (HALF_UNIT != 0);
  assign disp.blank    = blank_q;
  assign disp.ovf      = ovf_q;

endmodule

// File: tb/tb_coin_disp_fmt.sv
// Bench for coin_disp_fmt: two configurations (default and 3-digit integer-only) checked
// every cycle against an arithmetic reference model, plus directed literal expectations.
module tb_coin_disp_fmt;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errs   = 0;
  bit chk_en = 1'b0;

  typedef struct packed {
    logic [15:0] ib;
    logic [3:0]  fb;
    logic        ovf;
    logic [3:0]  bl;
  } res_t;

  function automatic int vw(int k);  return (k == 1) ? 10 : 8; endfunction
  function automatic int idg(int k); return (k == 1) ? 3 : 2;  endfunction
  function automatic int hu(int k);  return (k == 1) ? 0 : 1;  endfunction
  function automatic int lat(int k); return vw(k) - hu(k) + 1; endfunction

  // Expected display for a coin total, straight from decimal arithmetic.
  function automatic res_t model(int k, int v);
    res_t r;
    int   i, mx;
    r  = '0;
    i  = v >> hu(k);
    mx = 1;
    for (int d = 0; d < idg(k); d++) mx = mx * 10;
    mx = mx - 1;
    if (i > mx) begin
      for (int d = 0; d < idg(k); d++) r.ib[4*d+:4] = 4'd9;
      r.fb  = (hu(k) == 1) ? 4'd5 : 4'd0;
      r.ovf = 1'b1;
    end else begin
      for (int d = 0; d < idg(k); d++) begin
        r.ib[4*d+:4] = 4'(i % 10);
        i = i / 10;
      end
      r.fb = (hu(k) == 1 && (v % 2) == 1) ? 4'd5 : 4'd0;
    end
    for (int d = 1; d < idg(k); d++) r.bl[d] = ((r.ib >> (4 * d)) == 16'd0);
    return r;
  endfunction

  function automatic res_t rst_res(int k);
    res_t r;
    r    = '0;
    r.bl = 4'((1 << idg(k)) - 2);
    return r;
  endfunction

  logic        ld[2];
  logic [15:0] val[2];
  logic        a_busy[2], a_done[2], a_dp[2], a_ovf[2];
  logic [15:0] a_int[2];
  logic [3:0]  a_frac[2], a_blank[2];

  coin_disp_fmt_if #(.VAL_W(8),  .INT_DIGITS(2)) if0 ();
  coin_disp_fmt_if #(.VAL_W(10), .INT_DIGITS(3)) if1 ();

  coin_disp_fmt #(.VAL_W(8), .INT_DIGITS(2), .HALF_UNIT(1), .BLANK_LZ(1)) dut0 (
    .clk  (clk),
    .rst  (rst),
    .disp (if0)
  );
  coin_disp_fmt #(.VAL_W(10), .INT_DIGITS(3), .HALF_UNIT(0), .BLANK_LZ(1)) dut1 (
    .clk  (clk),
    .rst  (rst),
    .disp (if1)
  );

  assign if0.load   = ld[0];
  assign if0.value  = val[0][7:0];
  assign if1.load   = ld[1];
  assign if1.value  = val[1][9:0];
  assign a_busy[0]  = if0.busy;
  assign a_done[0]  = if0.done;
  assign a_dp[0]    = if0.dp;
  assign a_ovf[0]   = if0.ovf;
  assign a_int[0]   = 16'(if0.int_bcd);
  assign a_frac[0]  = if0.frac_bcd;
  assign a_blank[0] = 4'(if0.blank);
  assign a_busy[1]  = if1.busy;
  assign a_done[1]  = if1.done;
  assign a_dp[1]    = if1.dp;
  assign a_ovf[1]   = if1.ovf;
  assign a_int[1]   = 16'(if1.int_bcd);
  assign a_frac[1]  = if1.frac_bcd;
  assign a_blank[1] = 4'(if1.blank);

  // Timeline model: a conversion occupies lat(k) cycles after the accepting edge.
  int   m_cnt[2];
  int   m_pend[2];
  res_t m_res[2];
  logic m_done[2];

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_cnt[k]  <= 0;
        m_pend[k] <= 0;
        m_res[k]  <= rst_res(k);
        m_done[k] <= 1'b0;
      end else begin
        m_done[k] <= 1'b0;
        if (m_cnt[k] == 0) begin
          if (ld[k]) begin
            m_cnt[k]  <= 1;
            m_pend[k] <= int'(val[k]) & ((1 << vw(k)) - 1);
          end
        end else if (m_cnt[k] == lat(k)) begin
          m_cnt[k]  <= 0;
          m_res[k]  <= model(k, m_pend[k]);
          m_done[k] <= 1'b1;
        end else begin
          m_cnt[k] <= m_cnt[k] + 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s lane%0d: got %0h expected %0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk("busy",  k, 32'(a_busy[k]),  32'(m_cnt[k] != 0));
        chk("done",  k, 32'(a_done[k]),  32'(m_done[k]));
        chk("int",   k, 32'(a_int[k]),   32'(m_res[k].ib));
        chk("frac",  k, 32'(a_frac[k]),  32'(m_res[k].fb));
        chk("dp",    k, 32'(a_dp[k]),    32'(hu(k)));
        chk("blank", k, 32'(a_blank[k]), 32'(m_res[k].bl));
        chk("ovf",   k, 32'(a_ovf[k]),   32'(m_res[k].ovf));
      end
    end
  end

  task automatic conv(input int k, input int v, input int sec_at, input int rst_at,
                      output int first, output int nd);
    first = -1;
    nd    = 0;
    @(negedge clk);
    ld[k]  = 1'b1;
    val[k] = 16'(v);
    @(negedge clk);
    ld[k]  = 1'b0;
    val[k] = 16'($urandom);
    for (int n = 1; n <= lat(k) + 4; n++) begin
      @(negedge clk);
      if (a_done[k]) begin
        nd++;
        if (first < 0) first = n;
      end
      ld[k]  = (n == sec_at);
      val[k] = (n == sec_at) ? 16'd10 : 16'($urandom);
      if (rst_at > 0 && n == rst_at) begin
        #2 rst = 1'b1;
      end
      if (rst_at > 0 && n == rst_at + 1) begin
        #2 rst = 1'b0;
        break;
      end
    end
    ld[k] = 1'b0;
  endtask

  function automatic logic [15:0] pick(int k);
    int sel;
    sel = int'($urandom_range(0, 7));
    if ($urandom_range(0, 3) != 0) return 16'($urandom);
    if (k == 0) begin
      case (sel)
        0: return 16'd0;   1: return 16'd1;   2: return 16'd198; 3: return 16'd199;
        4: return 16'd200; 5: return 16'd201; 6: return 16'd255; default: return 16'd47;
      endcase
    end
    case (sel)
      0: return 16'd0;    1: return 16'd1;    2: return 16'd999; 3: return 16'd1000;
      4: return 16'd1001; 5: return 16'd1023; 6: return 16'd123; default: return 16'd5;
    endcase
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t r;
    int   first, nd;
    ld[0] = 1'b0; ld[1] = 1'b0; val[0] = '0; val[1] = '0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    // Model pins and reset state.
    r = model(0, 47);  chk("m47_int", 0, 32'(r.ib), 32'h23);  chk("m47_frac", 0, 32'(r.fb), 5);
    r = model(0, 14);  chk("m14_int", 0, 32'(r.ib), 32'h07);  chk("m14_blank", 0, 32'(r.bl), 2);
    r = model(0, 200); chk("m200_int", 0, 32'(r.ib), 32'h99); chk("m200_ovf", 0, 32'(r.ovf), 1);
    r = model(1, 123); chk("m123_int", 1, 32'(r.ib), 32'h123);
    r = model(1, 5);   chk("m5_blank", 1, 32'(r.bl), 3'b110);
    chk("rst_int",   0, 32'(a_int[0]),   0);
    chk("rst_blank", 0, 32'(a_blank[0]), 2'b10);
    chk("rst_dp",    0, 32'(a_dp[0]),    1);
    chk("rst_blank", 1, 32'(a_blank[1]), 3'b110);

    conv(0, 47, 0, 0, first, nd);
    chk("lat47", 0, 32'(first), 8);
    chk("ndone47", 0, 32'(nd), 1);
    chk("t1_int", 0, 32'(a_int[0]), 32'h23);
    chk("t1_blank", 0, 32'(a_blank[0]), 0);
    conv(0, 14, 0, 0, first, nd);
    chk("t2_int", 0, 32'(a_int[0]), 32'h07);
    chk("t2_blank", 0, 32'(a_blank[0]), 2'b10);
    conv(0, 0, 0, 0, first, nd);
    chk("t2z_int", 0, 32'(a_int[0]), 0);
    conv(0, 200, 0, 0, first, nd);
    chk("t3_ovf", 0, 32'(a_ovf[0]), 1);
    chk("t3_frac", 0, 32'(a_frac[0]), 5);
    conv(0, 199, 0, 0, first, nd);
    chk("t3b_ovf", 0, 32'(a_ovf[0]), 0);
    chk("t3b_int", 0, 32'(a_int[0]), 32'h99);
    conv(0, 47, 2, 0, first, nd);
    chk("t4_ndone", 0, 32'(nd), 1);
    chk("t4_int", 0, 32'(a_int[0]), 32'h23);
    conv(0, 47, 0, 4, first, nd);
    chk("t5_ndone", 0, 32'(nd), 0);
    chk("t5_int", 0, 32'(a_int[0]), 0);
    chk("t5_frac", 0, 32'(a_frac[0]), 0);
    conv(0, 47, 0, 0, first, nd);
    chk("t5b_int", 0, 32'(a_int[0]), 32'h23);
    chk("t5b_frac", 0, 32'(a_frac[0]), 5);
    conv(1, 123, 0, 0, first, nd);
    chk("lat123", 1, 32'(first), 11);
    chk("t6_int", 1, 32'(a_int[1]), 32'h123);
    chk("t6_dp", 1, 32'(a_dp[1]), 0);
    conv(1, 5, 0, 0, first, nd);
    chk("t6_blank", 1, 32'(a_blank[1]), 3'b110);

    // Random traffic on both lanes, with loads and value changes while busy.
    for (int c = 0; c < 1200; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        ld[k]  = ($urandom_range(0, 2) == 0);
        val[k] = pick(k);
      end
      if (c == 600) begin
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
      end
    end
    ld[0] = 1'b0; ld[1] = 1'b0;
    repeat (20) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
